// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: frames go out back-to-back while words are queued.
// Optional: define UART_TX_BREAK_EN to add the tx_break port and the BREAK/MARK states.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int BREAK_BITS = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                          tx_break
`endif
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int SW           = DATA_BITS + 1;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
`ifdef UART_TX_BREAK_EN
  localparam int BREAK_CLKS   = BREAK_BITS * CLKS_PER_BIT;
`else
  localparam int BREAK_CLKS   = 1;
`endif
  localparam int MAX_CLKS     = (BREAK_CLKS > STOP_CLKS) ? BREAK_CLKS : STOP_CLKS;
  localparam int CW           = $clog2(MAX_CLKS);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_fifo: DATA_BITS must be within 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || BREAK_BITS < 1) begin : g_chk_misc
    $error("uart_tx_fifo: PARITY, STOP_BITS or BREAK_BITS out of range");
  end

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [SW-1:0]        sh_q, sh_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 push, pop, start, bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign head     = mem_q[rd_ptr_q];
  assign head_par = (PARITY == 1) ? ~^head : ^head;
  assign push     = tx_valid && !full_q;
  assign pop      = start;
  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Parity rides in the shift register's MSB so it reaches bit 0 after the last data bit.
  always_comb begin : fsm_next
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else
`endif
        if (count_q != '0) start = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = sh_q[1];
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = sh_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(STOP_CLKS - 1)) begin
          if (count_q != '0) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (cnt_q == CW'(BREAK_CLKS - 1)) begin
          cnt_d = cnt_q;
          if (!tx_break) begin
            state_d = S_MARK;
            tx_d    = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_MARK: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    if (start) begin
      state_d = S_START;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = '0;
      bit_d   = '0;
      sh_d    = {head_par, head};
    end
  end

  always_comb begin : fifo_next
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    full_d = (count_d == (AW + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx_ready   = !full_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 8N2) at 10 clocks per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid_w, ready_w, tx_w, busy_w;
  logic [7:0] data_w [4];
  logic [4:0] cnt_w  [4];

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .reset(reset), .tx_data(data_w[0]), .tx_valid(valid_w[0]), .tx_ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16), .PARITY(2)) u1 (
    .clk(clk), .reset(reset), .tx_data(data_w[1]), .tx_valid(valid_w[1]), .tx_ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16), .PARITY(1)) u2 (
    .clk(clk), .reset(reset), .tx_data(data_w[2]), .tx_valid(valid_w[2]), .tx_ready(ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_data(data_w[3]), .tx_valid(valid_w[3]), .tx_ready(ready_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  // Expected line image: bit0 start, data LSB first, optional parity, then stop bits.
  function automatic logic [11:0] frame_of(input logic [7:0] d, input int par, input int stop);
    logic [11:0] f;
    int n;
    f = '0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    n = 9;
    if (par == 1) begin f[n] = ~(^d); n++; end
    else if (par == 2) begin f[n] = ^d; n++; end
    for (int s = 0; s < stop; s++) f[n + s] = 1'b1;
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input int k, input logic [7:0] w, output bit ok);
    bit acc;
    ok = 1'b0;
    data_w[k]  = w;
    valid_w[k] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      acc = ready_w[k];
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        exp_q.push_back(w);
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Waits for a start bit, then samples nb bit periods of 10 clocks each.
  task automatic capture(input int k, input int nb, output logic [11:0] bits,
                         output int unstable, output int busy_cnt, output int gap, output bit to);
    bits = '0; unstable = 0; busy_cnt = 0; gap = 0; to = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_w[k] === 1'b0) break;
      gap++;
      if (gap > 2000) begin to = 1'b1; return; end
    end
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < 10; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (s == 0) bits[b] = tx_w[k];
        else if (tx_w[k] !== bits[b]) unstable++;
        if (busy_w[k] === 1'b1) busy_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      vectors++; if (tx_w[k] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d]: got %b want 1", k, tx_w[k]); end
      vectors++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy_w[k]); end
      vectors++; if (ready_w[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", k, ready_w[k]); end
      vectors++; if (cnt_w[k] !== 5'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d want 0", k, cnt_w[k]); end
    end
  endtask

  task automatic test_frame_8n1();
    bit ok, to; logic [11:0] bits; int un, bz, gap; logic [7:0] e;
    exp_q.delete();
    push_word(0, 8'h55, ok);
    valid_w[0] = 1'b0;
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL 8n1_push: got %b want 1", ok); end
    vectors++; if (cnt_w[0] !== 5'd1) begin errors++; $display("FAIL 8n1_count1: got %0d want 1", cnt_w[0]); end
    vectors++; if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL 8n1_tx_before: got %b want 1", tx_w[0]); end
    capture(0, 10, bits, un, bz, gap, to);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    vectors++; if (to !== 1'b0) begin errors++; $display("FAIL 8n1_timeout: got %b want 0", to); end
    vectors++; if (gap !== 0) begin errors++; $display("FAIL 8n1_latency: got %0d want 0", gap); end
    vectors++; if (bits !== frame_of(e, 0, 1)) begin errors++; $display("FAIL 8n1_bits: got %h want %h", bits, frame_of(e, 0, 1)); end
    vectors++; if (un !== 0) begin errors++; $display("FAIL 8n1_bit_width: got %0d want 0", un); end
    vectors++; if (bz !== 100) begin errors++; $display("FAIL 8n1_busy_len: got %0d want 100", bz); end
    @(negedge clk);
    vectors++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end: got %b want 0", busy_w[0]); end
    vectors++; if (cnt_w[0] !== 5'd0) begin errors++; $display("FAIL 8n1_count0: got %0d want 0", cnt_w[0]); end
  endtask

  task automatic test_parity();
    bit ok, to; logic [11:0] bits; int un, bz, gap; logic [7:0] e;
    for (int k = 1; k <= 2; k++) begin
      exp_q.delete();
      push_word(k, 8'h07, ok);
      valid_w[k] = 1'b0;
      capture(k, 11, bits, un, bz, gap, to);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      vectors++; if (to !== 1'b0 || gap !== 0) begin errors++; $display("FAIL par%0d_start: got to=%b gap=%0d want 0/0", k, to, gap); end
      vectors++; if (bits !== frame_of(e, (k == 1) ? 2 : 1, 1)) begin errors++; $display("FAIL par%0d_bits: got %h want %h", k, bits, frame_of(e, (k == 1) ? 2 : 1, 1)); end
      vectors++; if (bits[9] !== ((k == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL par%0d_bit: got %b want %b", k, bits[9], (k == 1) ? 1'b1 : 1'b0); end
      vectors++; if (un !== 0 || bz !== 110) begin errors++; $display("FAIL par%0d_len: got unstable=%0d busy=%0d want 0/110", k, un, bz); end
      @(negedge clk);
      vectors++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL par%0d_busy_end: got %b want 0", k, busy_w[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [18];
    logic [11:0] fb [18];
    int fu [18], fbz [18], fg [18];
    bit fto [18];
    bit ok18;
    logic [7:0] e;
    exp_q.delete();
    for (int i = 0; i < 18; i++) words[i] = 8'($urandom_range(0, 255));
    fork
      begin
        bit ok;
        for (int i = 0; i < 18; i++) begin
          push_word(0, words[i], ok);
          if (i == 16) begin
            vectors++; if (cnt_w[0] !== 5'd16) begin errors++; $display("FAIL b2b_full_count: got %0d want 16", cnt_w[0]); end
            vectors++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", ready_w[0]); end
          end
        end
        ok18 = ok;
        valid_w[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 18; i++) capture(0, 10, fb[i], fu[i], fbz[i], fg[i], fto[i]);
      end
    join
    vectors++; if (ok18 !== 1'b1) begin errors++; $display("FAIL b2b_push18: got %b want 1", ok18); end
    for (int i = 0; i < 18; i++) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      vectors++; if (fto[i] !== 1'b0) begin errors++; $display("FAIL b2b_timeout[%0d]: got %b want 0", i, fto[i]); end
      vectors++; if (fb[i] !== frame_of(e, 0, 1)) begin errors++; $display("FAIL b2b_bits[%0d]: got %h want %h", i, fb[i], frame_of(e, 0, 1)); end
      vectors++; if (fg[i] !== ((i == 0) ? 1 : 0)) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, fg[i], (i == 0) ? 1 : 0); end
      vectors++; if (fu[i] !== 0 || fbz[i] !== 100) begin errors++; $display("FAIL b2b_len[%0d]: got unstable=%0d busy=%0d want 0/100", i, fu[i], fbz[i]); end
    end
    @(negedge clk);
    vectors++; if (busy_w[0] !== 1'b0 || cnt_w[0] !== 5'd0) begin errors++; $display("FAIL b2b_end: got busy=%b count=%0d want 0/0", busy_w[0], cnt_w[0]); end
  endtask

  task automatic test_stop2();
    logic [11:0] b1, b2; int u1, u2, z1, z2, g1, g2; bit t1, t2; logic [7:0] e;
    exp_q.delete();
    fork
      begin
        bit ok;
        push_word(3, 8'hA3, ok);
        push_word(3, 8'h3C, ok);
        valid_w[3] = 1'b0;
      end
      begin
        capture(3, 11, b1, u1, z1, g1, t1);
        capture(3, 11, b2, u2, z2, g2, t2);
      end
    join
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    vectors++; if (t1 !== 1'b0 || b1 !== frame_of(e, 0, 2)) begin errors++; $display("FAIL stop2_frame1: got %h to=%b want %h", b1, t1, frame_of(e, 0, 2)); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    vectors++; if (t2 !== 1'b0 || b2 !== frame_of(e, 0, 2)) begin errors++; $display("FAIL stop2_frame2: got %h to=%b want %h", b2, t2, frame_of(e, 0, 2)); end
    vectors++; if (g2 !== 0) begin errors++; $display("FAIL stop2_gap: got %0d want 0", g2); end
    vectors++; if (u1 + u2 !== 0) begin errors++; $display("FAIL stop2_width: got %0d want 0", u1 + u2); end
    vectors++; if (z1 + z2 !== 220) begin errors++; $display("FAIL stop2_busy: got %0d want 220", z1 + z2); end
    @(negedge clk);
    vectors++; if (busy_w[3] !== 1'b0) begin errors++; $display("FAIL stop2_busy_end: got %b want 0", busy_w[3]); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, to; logic [11:0] bits; int un, bz, gap; logic [7:0] e;
    logic [7:0] q4 [4];
    q4[0] = 8'hF0; q4[1] = 8'h11; q4[2] = 8'h22; q4[3] = 8'h33;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_word(0, q4[i], ok);
    valid_w[0] = 1'b0;
    repeat (52) @(negedge clk);
    vectors++; if (busy_w[0] !== 1'b1 || cnt_w[0] !== 5'd3) begin errors++; $display("FAIL rst_pre: got busy=%b count=%0d want 1/3", busy_w[0], cnt_w[0]); end
    reset = 1'b1;
    #1;
    vectors++; if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx_w[0]); end
    vectors++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_w[0]); end
    vectors++; if (cnt_w[0] !== 5'd0 || ready_w[0] !== 1'b1) begin errors++; $display("FAIL rst_fifo: got count=%0d ready=%b want 0/1", cnt_w[0], ready_w[0]); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_word(0, 8'h81, ok);
    valid_w[0] = 1'b0;
    capture(0, 10, bits, un, bz, gap, to);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    vectors++; if (to !== 1'b0 || gap !== 0) begin errors++; $display("FAIL rst_after_start: got to=%b gap=%0d want 0/0", to, gap); end
    vectors++; if (bits !== frame_of(e, 0, 1)) begin errors++; $display("FAIL rst_after_bits: got %h want %h", bits, frame_of(e, 0, 1)); end
    vectors++; if (un !== 0 || bz !== 100) begin errors++; $display("FAIL rst_after_len: got unstable=%0d busy=%0d want 0/100", un, bz); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    valid_w = '0;
    for (int k = 0; k < 4; k++) data_w[k] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_frame_8n1();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
